// File: rtl/simd_bram_dma_pkg.sv
// Shared types and defaults for the SIMD operand-BRAM port-B DMA master.
package simd_dma_pkg;

   localparam int unsigned LANES_DEF   = 16;
   localparam int unsigned DW_DEF      = 32;
   localparam int unsigned AW          = 32;
   localparam logic [AW-1:0] A_BASE_DEF  = 32'd0;
   localparam logic [AW-1:0] B_BASE_DEF  = 32'd16;
   localparam logic [AW-1:0] R_BASE_DEF  = 32'd32;
   localparam logic [3:0]    WE_CODE_DEF = 4'h7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_ISSUE,
      S_WAIT_RES,
      S_STORE,
      S_DONE
   } dma_state_e;

   // Saturating 32-bit increment for the pass-duration counter.
   function automatic logic [AW-1:0] sat_inc32(input logic [AW-1:0] v);
      return (v == {AW{1'b1}}) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/simd_bram_dma_if.sv
// Bundle of control, BRAM port-B and SIMD handshake signals for simd_bram_dma.
interface simd_bram_dma_if
   import simd_dma_pkg::*;
#(
   parameter int unsigned LANES = LANES_DEF,
   parameter int unsigned DW    = DW_DEF
);
   logic                      start;
   logic                      busy;
   logic                      done;
   logic [AW-1:0]             addrb;
   logic [DW-1:0]             dinb;
   logic [DW-1:0]             doutb;
   logic                      enb;
   logic [3:0]                web;
   logic [LANES-1:0][DW-1:0]  vec_a;
   logic [LANES-1:0][DW-1:0]  vec_b;
   logic                      op_valid;
   logic                      op_ready;
   logic [LANES-1:0][DW-1:0]  res;
   logic                      res_valid;
   logic                      res_ready;
   logic [AW-1:0]             cycle_count;

   modport master (
      input  start, doutb, op_ready, res, res_valid,
      output busy, done, addrb, dinb, enb, web, vec_a, vec_b,
             op_valid, res_ready, cycle_count
   );

   modport slave (
      output start, doutb, op_ready, res, res_valid,
      input  busy, done, addrb, dinb, enb, web, vec_a, vec_b,
             op_valid, res_ready, cycle_count
   );
endinterface

// File: rtl/simd_bram_dma_addr_gen.sv
// Lane index counter plus base+idx adder; nxt_addr_o is the address for the
// index the counter will hold after this edge, so the top can register it.
module simd_dma_addr_gen
   import simd_dma_pkg::*;
#(
   parameter int unsigned LANES = LANES_DEF,
   localparam int unsigned IW   = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          inc_i,
   input  logic [AW-1:0] base_i,
   output logic [IW-1:0] idx_o,
   output logic [IW-1:0] nxt_idx_o,
   output logic          last_o,
   output logic [AW-1:0] nxt_addr_o
);

   logic [IW-1:0] idx_q;
   logic [IW-1:0] idx_d;

   always_comb begin
      idx_d = idx_q;
      if (clr_i)      idx_d = '0;
      else if (inc_i) idx_d = idx_q + IW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) idx_q <= '0;
      else       idx_q <= idx_d;
   end

   assign idx_o      = idx_q;
   assign nxt_idx_o  = idx_d;
   assign last_o     = (idx_q == IW'(LANES - 1));
   assign nxt_addr_o = base_i + AW'(idx_d);

endmodule

// File: rtl/simd_bram_dma.sv
// Port-B DMA master: loads vectors A/B from BRAM, hands them to the SIMD array,
// stores the result back. Define SIMD_DMA_CYCLE_CNT_EN to enable cycle_count.
module simd_bram_dma
   import simd_dma_pkg::*;
#(
   parameter int unsigned   LANES   = LANES_DEF,
   parameter int unsigned   DW      = DW_DEF,
   parameter logic [AW-1:0] A_BASE  = A_BASE_DEF,
   parameter logic [AW-1:0] B_BASE  = B_BASE_DEF,
   parameter logic [AW-1:0] R_BASE  = R_BASE_DEF,
   parameter logic [3:0]    WE_CODE = WE_CODE_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   simd_bram_dma_if.master  dma
);

   localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

   dma_state_e               state_q;
   logic [AW-1:0]            addrb_q;
   logic [DW-1:0]            dinb_q;
   logic                     enb_q;
   logic [3:0]               web_q;
   logic [LANES-1:0][DW-1:0] vec_a_q;
   logic [LANES-1:0][DW-1:0] vec_b_q;
   logic [LANES-1:0][DW-1:0] resbuf_q;
   logic                     op_valid_q;
   logic                     res_ready_q;
   logic                     done_q;
   logic                     busy_q;

   logic                     clr_c;
   logic                     inc_c;
   logic [AW-1:0]            base_c;
   logic [IW-1:0]            idx;
   logic [IW-1:0]            nxt_idx;
   logic                     last;
   logic [AW-1:0]            nxt_addr;

   simd_dma_addr_gen #(.LANES(LANES)) u_addr_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_c),
      .inc_i      (inc_c),
      .base_i     (base_c),
      .idx_o      (idx),
      .nxt_idx_o  (nxt_idx),
      .last_o     (last),
      .nxt_addr_o (nxt_addr)
   );

   // Index control; base_c selects the region the next cycle will address.
   always_comb begin
      clr_c  = 1'b0;
      inc_c  = 1'b0;
      base_c = A_BASE;
      unique case (state_q)
         S_IDLE:     clr_c = dma.start;
         S_LOAD_A: begin
            inc_c  = !last;
            clr_c  = last;
            base_c = last ? B_BASE : A_BASE;
         end
         S_LOAD_B: begin
            inc_c  = !last;
            clr_c  = last;
            base_c = B_BASE;
         end
         S_WAIT_RES: begin
            clr_c  = dma.res_valid;
            base_c = R_BASE;
         end
         S_STORE: begin
            inc_c  = !last;
            clr_c  = last;
            base_c = R_BASE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         addrb_q     <= '0;
         dinb_q      <= '0;
         enb_q       <= 1'b0;
         web_q       <= '0;
         vec_a_q     <= '0;
         vec_b_q     <= '0;
         resbuf_q    <= '0;
         op_valid_q  <= 1'b0;
         res_ready_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (dma.start) begin
                  state_q <= S_LOAD_A;
                  busy_q  <= 1'b1;
                  enb_q   <= 1'b1;
                  addrb_q <= nxt_addr;
               end
            end
            S_LOAD_A: begin
               vec_a_q[idx] <= dma.doutb;
               addrb_q      <= nxt_addr;
               if (last) state_q <= S_LOAD_B;
            end
            S_LOAD_B: begin
               vec_b_q[idx] <= dma.doutb;
               if (last) begin
                  state_q    <= S_ISSUE;
                  enb_q      <= 1'b0;
                  op_valid_q <= 1'b1;
               end else begin
                  addrb_q <= nxt_addr;
               end
            end
            S_ISSUE: begin
               if (dma.op_ready) begin
                  state_q     <= S_WAIT_RES;
                  op_valid_q  <= 1'b0;
                  res_ready_q <= 1'b1;
               end
            end
            S_WAIT_RES: begin
               // Lane 0 goes straight to dinb so the first write needs no extra cycle.
               if (dma.res_valid) begin
                  state_q     <= S_STORE;
                  res_ready_q <= 1'b0;
                  resbuf_q    <= dma.res;
                  enb_q       <= 1'b1;
                  web_q       <= WE_CODE;
                  addrb_q     <= nxt_addr;
                  dinb_q      <= dma.res[0];
               end
            end
            S_STORE: begin
               if (last) begin
                  state_q <= S_DONE;
                  enb_q   <= 1'b0;
                  web_q   <= '0;
                  done_q  <= 1'b1;
               end else begin
                  addrb_q <= nxt_addr;
                  dinb_q  <= resbuf_q[nxt_idx];
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef SIMD_DMA_CYCLE_CNT_EN
   logic [AW-1:0] cnt_q;

   // Counts every busy cycle including DONE, then holds until the next start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (dma.start) cnt_q <= '0;
      end else begin
         cnt_q <= sat_inc32(cnt_q);
      end
   end

   assign dma.cycle_count = cnt_q;
`else
   assign dma.cycle_count = '0;
`endif

   assign dma.busy      = busy_q;
   assign dma.done      = done_q;
   assign dma.addrb     = addrb_q;
   assign dma.dinb      = dinb_q;
   assign dma.enb       = enb_q;
   assign dma.web       = web_q;
   assign dma.vec_a     = vec_a_q;
   assign dma.vec_b     = vec_b_q;
   assign dma.op_valid  = op_valid_q;
   assign dma.res_ready = res_ready_q;

endmodule

// File: tb/tb_simd_bram_dma.sv
// Scoreboard bench for simd_bram_dma: BRAM model, A+B datapath model, expected writes queued.
module tb_simd_bram_dma;
   import simd_dma_pkg::*;

   localparam int unsigned   LANES    = 16;
   localparam int unsigned   DW       = 32;
   localparam logic [31:0]   R_BASE   = 32'd32;
   localparam int unsigned   MIN_PASS = 3 * LANES + 3;

   typedef struct packed {
      logic [31:0]   addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   simd_bram_dma_if #(.LANES(LANES), .DW(DW)) dma_if ();

   simd_bram_dma #(.LANES(LANES), .DW(DW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .dma   (dma_if)
   );

   logic [DW-1:0]            mem [0:63];
   logic [DW-1:0]            exp_a [LANES];
   logic [DW-1:0]            exp_b [LANES];
   logic [DW-1:0]            exp_r [LANES];
   logic [LANES-1:0][DW-1:0] pa;
   logic [LANES-1:0][DW-1:0] pb;
   wr_t                      sb_q [$];
   int                       n_cmp = 0;
   int                       n_bad = 0;
   int                       done_cnt = 0;
   int                       wr_cnt = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   assign dma_if.doutb = (dma_if.enb && dma_if.addrb < 32'd64) ? mem[dma_if.addrb[5:0]] : '0;

   // BRAM write port: every strobe must match the next queued expected write.
   always @(posedge clk) begin
      if (dma_if.enb && dma_if.web != 4'h0) begin
         wr_t e;
         wr_cnt++;
         check("web_code", dma_if.web, 4'h7);
         if (dma_if.addrb < 32'd64) mem[dma_if.addrb[5:0]] <= dma_if.dinb;
         if (sb_q.size() == 0) begin
            check("wr_unexpected", {dma_if.addrb, dma_if.dinb}, 0);
         end else begin
            e = sb_q.pop_front();
            check("bram_wr", {dma_if.addrb, dma_if.dinb}, e);
         end
      end
      if (dma_if.done) done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic run_pass(input int op_hold, input int res_dly, input bit stray, input int abort_idx);
      int n;
      int d0;
      int w0;
      int exp_end;
      int cexp;
      bit ok;
      logic [LANES-1:0][DW-1:0] sa;
      logic [LANES-1:0][DW-1:0] sbv;
      d0 = done_cnt;
      for (int i = 0; i < int'(LANES); i++) sb_q.push_back(wr_t'{R_BASE + 32'(i), exp_r[i]});
      dma_if.start = 1'b1;
      @(negedge clk);
      dma_if.start = 1'b0;
      n = 0;
      while (!dma_if.op_valid && n < 200) begin
         @(negedge clk);
         n++;
         dma_if.start = stray && (n == 20);
      end
      dma_if.start = 1'b0;
      check("issue_edge", n, 2 * LANES);
      if (op_hold > 0) begin
         sa = dma_if.vec_a;
         sbv = dma_if.vec_b;
         w0 = wr_cnt;
         ok = 1'b1;
         repeat (op_hold) begin
            @(negedge clk);
            n++;
            if (!dma_if.op_valid || dma_if.enb || dma_if.vec_a !== sa || dma_if.vec_b !== sbv) ok = 1'b0;
         end
         check("issue_hold", ok, 1);
         check("issue_no_wr", wr_cnt - w0, 0);
      end
      check("vec_a", dma_if.vec_a, pa);
      check("vec_b", dma_if.vec_b, pb);
      dma_if.op_ready = 1'b1;
      @(negedge clk);
      n++;
      dma_if.op_ready = 1'b0;
      check("res_ready", {dma_if.res_ready, dma_if.op_valid}, 2'b10);
      if (res_dly > 0) begin
         ok = 1'b1;
         repeat (res_dly) begin
            @(negedge clk);
            n++;
            if (!dma_if.res_ready || dma_if.op_valid || dma_if.enb) ok = 1'b0;
         end
         check("wait_hold", ok, 1);
      end
      for (int i = 0; i < int'(LANES); i++) dma_if.res[i] = dma_if.vec_a[i] + dma_if.vec_b[i];
      dma_if.res_valid = 1'b1;
      @(negedge clk);
      n++;
      dma_if.res_valid = 1'b0;
      check("store_start", {dma_if.res_ready, dma_if.enb, dma_if.web, dma_if.addrb, dma_if.dinb},
            {1'b0, 1'b1, 4'h7, R_BASE, exp_r[0]});
      if (abort_idx >= 0) begin
         repeat (abort_idx) @(negedge clk);
         check("abort_addr", dma_if.addrb, R_BASE + 32'(abort_idx));
         rst = 1'b1;
         #1;
         check("abort_outs", {dma_if.busy, dma_if.done, dma_if.enb, dma_if.web, dma_if.op_valid,
                              dma_if.res_ready, dma_if.addrb, dma_if.dinb, dma_if.cycle_count}, 0);
         check("abort_vec_a", dma_if.vec_a, 0);
         check("abort_vec_b", dma_if.vec_b, 0);
         check("abort_sb_left", sb_q.size(), LANES - 32'(abort_idx));
         sb_q.delete();
         @(negedge clk);
         rst = 1'b0;
      end else begin
         while (!dma_if.done && n < 300) begin
            @(negedge clk);
            n++;
         end
         exp_end = MIN_PASS + op_hold + res_dly;
         check("done_edge", n, exp_end - 1);
         dma_if.start = stray;
         @(negedge clk);
         n++;
         dma_if.start = 1'b0;
         check("idle_busy", {dma_if.busy, dma_if.done, dma_if.enb}, 0);
`ifdef SIMD_DMA_CYCLE_CNT_EN
         cexp = exp_end;
`else
         cexp = 0;
`endif
         check("cycle_count", dma_if.cycle_count, cexp);
         repeat (3) @(negedge clk);
         check("idle_after", {dma_if.busy, dma_if.enb}, 0);
         check("cycle_hold", dma_if.cycle_count, cexp);
         check("done_pulses", done_cnt - d0, 1);
         check("sb_empty", sb_q.size(), 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      dma_if.start = 1'b0;
      dma_if.op_ready = 1'b0;
      dma_if.res_valid = 1'b0;
      dma_if.res = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         exp_a[i] = 32'(3 * i + 11);
         exp_b[i] = 32'(90 - 2 * i);
      end
      exp_a[0] = 32'd15; exp_a[1] = 32'd20; exp_a[2] = 32'd42; exp_a[15] = 32'd7;
      exp_b[0] = 32'd48; exp_b[1] = 32'd35; exp_b[2] = 32'd33; exp_b[15] = 32'd1;
      for (int i = 0; i < int'(LANES); i++) begin
         exp_r[i] = exp_a[i] + exp_b[i];
         pa[i] = exp_a[i];
         pb[i] = exp_b[i];
      end
      for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_0000 + 32'(i);
      for (int i = 0; i < int'(LANES); i++) begin
         mem[i] = exp_a[i];
         mem[16 + i] = exp_b[i];
      end

      repeat (2) @(negedge clk);
      check("rst_outs", {dma_if.busy, dma_if.done, dma_if.enb, dma_if.web, dma_if.op_valid,
                         dma_if.res_ready, dma_if.addrb, dma_if.dinb, dma_if.cycle_count}, 0);
      check("rst_vec_a", dma_if.vec_a, 0);
      check("rst_vec_b", dma_if.vec_b, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_pass(0, 0, 1'b0, -1);
      check("bram32", mem[32], 32'd63);
      check("bram47", mem[47], 32'd8);

      run_pass(10, 0, 1'b0, -1);
      run_pass(0, 5, 1'b0, -1);

      for (int i = 0; i < int'(LANES); i++) mem[32 + i] = 32'hDEAD_0000 + 32'(i);
      run_pass(0, 0, 1'b0, 7);
      for (int i = 0; i < int'(LANES); i++)
         check($sformatf("abort_mem%0d", 32 + i), mem[32 + i], (i < 7) ? exp_r[i] : 32'hDEAD_0000 + 32'(i));

      repeat (2) @(negedge clk);
      run_pass(0, 0, 1'b0, -1);
      check("post_abort47", mem[47], 32'd8);

      run_pass(0, 0, 1'b1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
